alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- Execute-stage front end of the MIPS datapath; the initiator side of the ALU operand/control interface.
- Accepts decoded-instruction fields (ALUOp, funct, two operands) over a valid/ready handshake.
- Generates the 4-bit ALU control code and drives registered operands into the combinational ALU.
- Captures result and Zero into an output register with its own valid/ready handshake. It is a 2-stage elastic pipeline (E, W).

Parameters:
- WIDTH, 32, operand/result width.
- CTR_W, 4, ALU control code width.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  upstream op valid
- in_ready  output  1  stage can accept op this cycle
- in_aluop  input  2  main-control ALUOp
- in_funct  input  6  instruction funct field
- in_a  input  WIDTH  operand 1
- in_b  input  WIDTH  operand 2
- alu_in1  output  WIDTH  to ALU In1
- alu_in2  output  WIDTH  to ALU In2
- alu_ctr  output  CTR_W  to ALU ALUCtr
- alu_res  input  WIDTH  from ALU ALURes
- alu_zero  input  1  from ALU Zero
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_res  output  WIDTH  captured result
- out_zero  output  1  captured Zero
- out_ctr  output  CTR_W  control code that produced result
- out_illegal  output  1  unsupported funct flag (see Optional Feature)

Behaviour:
- ALU codes: AND=0, OR=1, ADD=2, SUB=6, SLT=7 (signed compare, result 1 or 0).
- Decode:
  - ALUOp 00 -> ADD.
  - ALUOp 01 -> SUB.
  - ALUOp 11 -> OR.
  - ALUOp 10 -> by funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT. Any other funct is unsupported.
- Stage E: e_valid plus registers e_a, e_b, e_ctr. alu_in1/alu_in2/alu_ctr are driven directly from these registers.
- Stage W: w_valid plus registers w_res, w_zero, w_ctr, w_ill. out_* are driven from these registers; out_valid = w_valid.
- Control equations:
  - w_adv = !w_valid | out_ready.
  - e_adv = e_valid & w_adv.
  - in_ready = !e_valid | w_adv (combinational, no dependence on in_valid).
- Accept (in_valid & in_ready): load E data registers, set e_valid next cycle.
- e_adv: load W from alu_res/alu_zero/e_ctr, set w_valid.
- out_valid & out_ready with no e_adv: clear w_valid.
- Accept while E empty and no e_adv: e_valid set.
- Accept with e_adv in the same cycle: E reloads, e_valid stays 1. Throughput is 1 op/cycle.
- Latency: op accepted at edge N appears on the ALU after edge N, and out_valid rises after edge N+1.
- E data registers change only on accept. When stalled or empty they hold, so ALU inputs are stable. W data registers change only on e_adv, so out_* are stable while out_valid & !out_ready.
- Full condition: e_valid & w_valid & !out_ready -> in_ready=0. Ops never drop or duplicate, and order is strict FIFO.
- Reset: e_valid=0, w_valid=0, all data registers=0, so alu_ctr=0, out_res=0, out_zero=0, out_ctr=0, out_illegal=0. After reset in_ready=1. Reset mid-operation discards in-flight ops with no output.
- out_zero copies alu_zero; it is not recomputed.

Optional Feature:
- Macro ALU_ILLEGAL_TRAP_EN.
- Defined: an unsupported funct with ALUOp 10 issues with alu_ctr=ADD, but W captures out_res=0, out_zero=0, out_illegal=1. The op still consumes a pipeline slot and handshake.
- Undefined: unsupported funct decodes to ADD, the result passes through, and out_illegal is tied to 0.

Decomposition:
- Shared package mips_alu_pkg: constants ALU_AND/OR/ADD/SUB/SLT, ALUOP_* codes, FUNCT_* codes, WIDTH/CTR_W defaults.
- One sub-module, alu_ctrl_decode: a combinational ALUOp+funct -> ctr/illegal decoder, reused by the ALU control unit.
- Pipeline registers stay in alu_issue_stage.

Test Plan:
- Bench drives alu_res/alu_zero from a reference ALU model.
- ADD: a=4, b=8, aluop=10, funct=100000 -> alu_ctr=2, out_res=12, out_zero=0, out_valid 2 edges after accept.
- SUB: a=4, b=8, aluop=01 -> out_res=0xFFFFFFFC, out_zero=0. Then a=b=0x44444444 -> out_res=0, out_zero=1.
- SLT/AND/OR: a=0x99999999, b=0x88888888, funct 101010 -> out_res=0. AND -> 0x88888888. OR -> 0x99999999. Issued back-to-back, in_ready stays 1 and results arrive on consecutive cycles.
- Backpressure: out_ready=0, offer 3 ops -> 2 accepted, in_ready=0, out_* stable. Release -> 3 results in order, no loss.
- Reset mid-flight: reset asserted with E and W full -> next cycle out_valid=0, out_res=0, alu_ctr=0, in_ready=1, and no stale result ever emitted.
- Illegal funct 111111 with aluop=10: with ALU_ILLEGAL_TRAP_EN -> out_illegal=1, out_res=0. Without -> out_res=a+b, out_illegal=0.

Source files
------------

// File: rtl/mips_alu_pkg.sv
// rtl/mips_alu_pkg.sv - shared ALU control codes, ALUOp/funct encodings and width defaults
package mips_alu_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CTR_W_DEF = 4;

  localparam logic [CTR_W_DEF-1:0] ALU_AND = 4'd0;
  localparam logic [CTR_W_DEF-1:0] ALU_OR  = 4'd1;
  localparam logic [CTR_W_DEF-1:0] ALU_ADD = 4'd2;
  localparam logic [CTR_W_DEF-1:0] ALU_SUB = 4'd6;
  localparam logic [CTR_W_DEF-1:0] ALU_SLT = 4'd7;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

endpackage

// File: rtl/alu_ctrl_decode.sv
// rtl/alu_ctrl_decode.sv - combinational ALUOp + funct to ALU control code decoder
module alu_ctrl_decode
  import mips_alu_pkg::*;
(
  input  logic [1:0]           aluop,
  input  logic [5:0]           funct,
  output logic [CTR_W_DEF-1:0] ctr,
  output logic                 illegal
);

  always_comb begin
    ctr     = ALU_ADD;
    illegal = 1'b0;
    case (aluop)
      ALUOP_ADD: ctr = ALU_ADD;
      ALUOP_SUB: ctr = ALU_SUB;
      ALUOP_OR:  ctr = ALU_OR;
      default: begin
        case (funct)
          FUNCT_ADD: ctr = ALU_ADD;
          FUNCT_SUB: ctr = ALU_SUB;
          FUNCT_AND: ctr = ALU_AND;
          FUNCT_OR:  ctr = ALU_OR;
          FUNCT_SLT: ctr = ALU_SLT;
          // Unsupported funct still issues as ADD so the slot is consumed.
          default: begin
            ctr     = ALU_ADD;
            illegal = 1'b1;
          end
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - two-stage elastic ALU issue/capture pipeline; ALU_ILLEGAL_TRAP_EN enables illegal-funct trapping
module alu_issue_stage
  import mips_alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CTR_W = CTR_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_aluop,
  input  logic [5:0]       in_funct,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [CTR_W-1:0] alu_ctr,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_zero,
  output logic [CTR_W-1:0] out_ctr,
  output logic             out_illegal
);

  logic                 e_valid, w_valid;
  logic [WIDTH-1:0]     e_a, e_b, w_res;
  logic [CTR_W-1:0]     e_ctr, w_ctr;
  logic                 w_zero, w_ill;
  logic [CTR_W_DEF-1:0] dec_ctr;
  logic                 dec_ill;
  logic                 w_adv, e_adv, accept;

  alu_ctrl_decode u_decode (
    .aluop   (in_aluop),
    .funct   (in_funct),
    .ctr     (dec_ctr),
    .illegal (dec_ill)
  );

  assign w_adv    = !w_valid | out_ready;
  assign e_adv    = e_valid & w_adv;
  assign in_ready = !e_valid | w_adv;
  assign accept   = in_valid & in_ready;

`ifdef ALU_ILLEGAL_TRAP_EN
  logic e_ill;

  always_ff @(posedge clk) begin
    if (reset) begin
      e_ill <= 1'b0;
      w_ill <= 1'b0;
    end else begin
      if (accept) e_ill <= dec_ill;
      if (e_adv)  w_ill <= e_ill;
    end
  end
`else
  logic unused_ill;
  assign unused_ill = dec_ill;
  assign w_ill      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      e_valid <= 1'b0;
      w_valid <= 1'b0;
      e_a     <= '0;
      e_b     <= '0;
      e_ctr   <= '0;
      w_res   <= '0;
      w_zero  <= 1'b0;
      w_ctr   <= '0;
    end else begin
      if (accept) begin
        e_valid <= 1'b1;
        e_a     <= in_a;
        e_b     <= in_b;
        e_ctr   <= CTR_W'(dec_ctr);
      end else if (e_adv) begin
        e_valid <= 1'b0;
      end

      if (e_adv) begin
        w_valid <= 1'b1;
        w_ctr   <= e_ctr;
`ifdef ALU_ILLEGAL_TRAP_EN
        // A trapped op reports a clean zero result rather than the ADD output.
        w_res   <= e_ill ? '0 : alu_res;
        w_zero  <= e_ill ? 1'b0 : alu_zero;
`else
        w_res   <= alu_res;
        w_zero  <= alu_zero;
`endif
      end else if (out_ready) begin
        w_valid <= 1'b0;
      end
    end
  end

  assign alu_in1     = e_a;
  assign alu_in2     = e_b;
  assign alu_ctr     = e_ctr;
  assign out_valid   = w_valid;
  assign out_res     = w_res;
  assign out_zero    = w_zero;
  assign out_ctr     = w_ctr;
  assign out_illegal = w_ill;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - directed self-checking bench for alu_issue_stage with a reference ALU
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_aluop;
  logic [5:0]  in_funct;
  logic [31:0] in_a, in_b;
  logic [31:0] alu_in1, alu_in2;
  logic [3:0]  alu_ctr;
  logic [31:0] alu_res;
  logic        alu_zero;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_res;
  logic        out_zero;
  logic [3:0]  out_ctr;
  logic        out_illegal;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_aluop    (in_aluop),
    .in_funct    (in_funct),
    .in_a        (in_a),
    .in_b        (in_b),
    .alu_in1     (alu_in1),
    .alu_in2     (alu_in2),
    .alu_ctr     (alu_ctr),
    .alu_res     (alu_res),
    .alu_zero    (alu_zero),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_res     (out_res),
    .out_zero    (out_zero),
    .out_ctr     (out_ctr),
    .out_illegal (out_illegal)
  );

  // Reference combinational ALU feeding the stage
  always_comb begin
    alu_res = 32'd0;
    case (alu_ctr)
      4'd0: alu_res = alu_in1 & alu_in2;
      4'd1: alu_res = alu_in1 | alu_in2;
      4'd2: alu_res = alu_in1 + alu_in2;
      4'd6: alu_res = alu_in1 - alu_in2;
      4'd7: alu_res = ($signed(alu_in1) < $signed(alu_in2)) ? 32'd1 : 32'd0;
      default: alu_res = 32'd0;
    endcase
    alu_zero = (alu_res == 32'd0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] op, input logic [5:0] fn);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_aluop = op;
    in_funct = fn;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_aluop = 2'b00; in_funct = 6'd0;
    step(); step();
    reset = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_alu_ctr", alu_ctr, 0);
    chk("rst_out_res", out_res, 0);
    chk("rst_out_zero", out_zero, 0);
    chk("rst_out_ctr", out_ctr, 0);
    chk("rst_out_illegal", out_illegal, 0);

    // ADD with latency check
    issue(32'd4, 32'd8, 2'b10, 6'b100000);
    step();
    in_valid = 1'b0;
    chk("add_alu_ctr", alu_ctr, 2);
    chk("add_alu_in1", alu_in1, 4);
    chk("add_alu_in2", alu_in2, 8);
    chk("add_not_yet", out_valid, 0);
    step();
    chk("add_valid", out_valid, 1);
    chk("add_res", out_res, 12);
    chk("add_zero", out_zero, 0);
    chk("add_ctr", out_ctr, 2);
    step();
    chk("add_drained", out_valid, 0);

    // SUB negative and zero results
    issue(32'd4, 32'd8, 2'b01, 6'd0);
    step(); in_valid = 1'b0; step();
    chk("sub_res", out_res, 32'hFFFF_FFFC);
    chk("sub_zero", out_zero, 0);
    chk("sub_ctr", out_ctr, 6);
    issue(32'h4444_4444, 32'h4444_4444, 2'b01, 6'd0);
    step(); in_valid = 1'b0; step();
    chk("sub0_res", out_res, 0);
    chk("sub0_zero", out_zero, 1);

    // SLT / AND / OR back-to-back
    step();
    issue(32'h9999_9999, 32'h8888_8888, 2'b10, 6'b101010);
    step();
    chk("b2b_rdy1", in_ready, 1);
    issue(32'h9999_9999, 32'h8888_8888, 2'b10, 6'b100100);
    step();
    chk("b2b_rdy2", in_ready, 1);
    chk("slt_valid", out_valid, 1);
    chk("slt_res", out_res, 0);
    chk("slt_ctr", out_ctr, 7);
    issue(32'h9999_9999, 32'h8888_8888, 2'b10, 6'b100101);
    step();
    in_valid = 1'b0;
    chk("and_valid", out_valid, 1);
    chk("and_res", out_res, 32'h8888_8888);
    chk("and_ctr", out_ctr, 0);
    step();
    chk("or_valid", out_valid, 1);
    chk("or_res", out_res, 32'h9999_9999);
    chk("or_ctr", out_ctr, 1);
    step();
    chk("b2b_drained", out_valid, 0);

    // Backpressure: three ops offered, two fit
    out_ready = 1'b0;
    issue(32'd1, 32'd2, 2'b00, 6'd0);
    chk("bp_rdy1", in_ready, 1);
    step();
    issue(32'd10, 32'd20, 2'b00, 6'd0);
    chk("bp_rdy2", in_ready, 1);
    step();
    issue(32'h0000_00F0, 32'h0000_000F, 2'b11, 6'd0);
    chk("bp_full", in_ready, 0);
    chk("bp_res_a", out_res, 3);
    step();
    chk("bp_full_hold", in_ready, 0);
    chk("bp_valid_hold", out_valid, 1);
    chk("bp_res_hold", out_res, 3);
    chk("bp_alu_in1_hold", alu_in1, 10);
    step();
    chk("bp_res_hold2", out_res, 3);
    out_ready = 1'b1;
    #1;
    chk("bp_release_rdy", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("bp_out2_valid", out_valid, 1);
    chk("bp_out2_res", out_res, 30);
    step();
    chk("bp_out3_valid", out_valid, 1);
    chk("bp_out3_res", out_res, 32'h0000_00FF);
    chk("bp_out3_ctr", out_ctr, 1);
    step();
    chk("bp_drained", out_valid, 0);

    // Reset with both stages occupied
    out_ready = 1'b0;
    issue(32'd7, 32'd7, 2'b00, 6'd0);
    step();
    issue(32'd9, 32'd1, 2'b01, 6'd0);
    step();
    in_valid = 1'b0;
    chk("mid_full", in_ready, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_out_valid", out_valid, 0);
    chk("mid_out_res", out_res, 0);
    chk("mid_alu_ctr", alu_ctr, 0);
    chk("mid_in_ready", in_ready, 1);
    chk("mid_out_ctr", out_ctr, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mid_no_stale", out_valid, 0);
    end

    // Unsupported funct
    issue(32'd5, 32'd7, 2'b10, 6'b111111);
    step();
    in_valid = 1'b0;
    chk("ill_alu_ctr", alu_ctr, 2);
    step();
    chk("ill_valid", out_valid, 1);
`ifdef ALU_ILLEGAL_TRAP_EN
    chk("ill_res", out_res, 0);
    chk("ill_zero", out_zero, 0);
    chk("ill_flag", out_illegal, 1);
`else
    chk("ill_res", out_res, 12);
    chk("ill_zero", out_zero, 0);
    chk("ill_flag", out_illegal, 0);
`endif
    step();
    chk("ill_drained", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
